// File: rtl/rr_hold_arbiter.sv
// rtl/rr_hold_arbiter.sv - round-robin arbiter with bounded grant hold and turnaround cycle
module rr_hold_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 expired
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);
    localparam logic [IW-1:0] LAST_ID    = IW'(N - 1);
    localparam logic [IW:0]   N_WIDE     = (IW + 1)'(N);
    localparam logic [N-1:0]  ONE_HOT0   = N'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, ptr_nxt;
    logic [IW-1:0]   owner, owner_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [N-1:0]    gnt_nxt;
    logic            expired_nxt;

    logic [2*N-1:0]  req_dbl;
    logic [N-1:0]    req_rot;
    logic [IW-1:0]   sel_off;
    logic [IW:0]     sel_sum;
    logic [IW-1:0]   sel_idx;
    logic [IW-1:0]   ptr_release;
    logic            owner_req;

    // Rotate req so bit 0 is the requester at ptr; lowest set bit is the winner.
    always_comb begin
        req_dbl = {req, req} >> ptr;
        req_rot = req_dbl[N-1:0];
        sel_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                sel_off = IW'(k);
            end
        end
        sel_sum = {1'b0, ptr} + {1'b0, sel_off};
        if (sel_sum >= N_WIDE) begin
            sel_idx = IW'(sel_sum - N_WIDE);
        end else begin
            sel_idx = sel_sum[IW-1:0];
        end
    end

    assign owner_req   = req[owner];
    assign ptr_release = (owner == LAST_ID) ? '0 : owner + 1'b1;

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        owner_nxt   = owner;
        cnt_nxt     = cnt;
        gnt_nxt     = gnt;
        expired_nxt = 1'b0;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (|req) begin
                    state_nxt = GRANT;
                    owner_nxt = sel_idx;
                    gnt_nxt   = ONE_HOT0 << sel_idx;
                    cnt_nxt   = CW'(1);
                end
            end
            GRANT: begin
                // A dropped request wins over a simultaneous timeout, so no expiry pulse then.
                if (!owner_req) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    cnt_nxt   = '0;
                    ptr_nxt   = ptr_release;
                end else if (cnt == HOLD_LIMIT) begin
                    state_nxt   = IDLE;
                    gnt_nxt     = '0;
                    cnt_nxt     = '0;
                    ptr_nxt     = ptr_release;
                    expired_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            cnt     <= '0;
            gnt     <= '0;
            expired <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            owner   <= owner_nxt;
            cnt     <= cnt_nxt;
            gnt     <= gnt_nxt;
            expired <= expired_nxt;
        end
    end

    assign busy   = |gnt;
    assign gnt_id = owner;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// tb/tb_rr_hold_arbiter.sv - self-checking bench for rr_hold_arbiter against a behavioural model
module tb_rr_hold_arbiter;

    localparam int N  = 4;
    localparam int MH = 8;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req   = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       expired;

    int passed = 0;
    int total  = 0;

    // Reference state: who owns the resource, for how long, and whose turn is next.
    bit m_busy;
    bit m_exp;
    int m_owner;
    int m_ptr;
    int m_cnt;

    rr_hold_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .expired (expired)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_exp   = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_cnt   = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        bit found;
        found = 1'b0;
        m_exp = 1'b0;
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (!found && ((r >> i) & 4'd1) != 4'd0) begin
                    found   = 1'b1;
                    m_owner = i;
                    m_busy  = 1'b1;
                    m_cnt   = 1;
                end
            end
        end else if (((r >> m_owner) & 4'd1) == 4'd0) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % N;
        end else if (m_cnt == MH) begin
            m_busy = 1'b0;
            m_exp  = 1'b1;
            m_ptr  = (m_owner + 1) % N;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] eg;
        eg = m_busy ? 4'(1 << m_owner) : 4'b0000;
        check({tag, ".gnt"}, 32'(gnt), 32'(eg));
        check({tag, ".busy"}, 32'(busy), 32'(m_busy));
        check({tag, ".expired"}, 32'(expired), 32'(m_exp));
        if (m_busy) check({tag, ".gnt_id"}, 32'(gnt_id), 32'(m_owner));
    endtask

    task automatic cycle(input logic [3:0] r, input string tag);
        req = r;
        @(posedge clk);
        if (reset) model_step(r);
        else model_reset();
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [3:0] r;
        logic [3:0] hold_req;

        // Reset held with all requesters active.
        model_reset();
        reset = 1'b0;
        req   = 4'b1111;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_all("reset");
            check("reset.gnt_id", 32'(gnt_id), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        cycle(4'b1111, "first");
        check("first.lit", 32'(gnt), 32'h1);
        cycle(4'b0000, "drop");
        cycle(4'b0000, "idle");

        // Short burst from requester 2.
        repeat (3) cycle(4'b0100, "burst");
        check("burst.id", 32'(gnt_id), 32'd2);
        cycle(4'b0000, "burst_rel");
        check("burst_rel.exp", 32'(expired), 32'd0);
        check("burst_rel.gnt", 32'(gnt), 32'd0);

        // Saturation: rotating grants, each ending with a timeout pulse.
        repeat (40) cycle(4'b1111, "sat");
        cycle(4'b0000, "sat_end");
        cycle(4'b0000, "sat_idle");

        // Requester 1 runs to timeout, leaving ptr at 2; then 1001 must grant 3 first.
        repeat (MH + 1) cycle(4'b0010, "own1");
        check("own1.exp", 32'(expired), 32'd1);
        cycle(4'b1001, "skip");
        check("skip.lit", 32'(gnt), 32'h8);
        repeat (20) cycle(4'b1001, "skip");
        cycle(4'b0000, "skip_end");
        cycle(4'b0000, "skip_idle");

        // Owner drops its request on the same edge its hold limit is reached.
        for (int i = 0; i < 40 && !(m_busy && m_cnt == MH); i++) cycle(4'b1111, "sim_wait");
        check("sim.reached", 32'(m_busy && m_cnt == MH), 32'd1);
        hold_req = 4'b1111 & ~4'(1 << m_owner);
        cycle(hold_req, "sim_drop");
        check("sim.exp", 32'(expired), 32'd0);
        check("sim.idle", 32'(gnt), 32'd0);
        cycle(hold_req, "sim_next");
        cycle(4'b0000, "sim_end");
        cycle(4'b0000, "sim_idle");

        // Asynchronous reset in the middle of a grant to requester 2.
        cycle(4'b0100, "mid");
        cycle(4'b0100, "mid");
        check("mid.lit", 32'(gnt), 32'h4);
        #2;
        reset = 1'b0;
        #1;
        check("mid.async_gnt", 32'(gnt), 32'd0);
        check("mid.async_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        cycle(4'b0101, "mid_after");
        check("mid_after.lit", 32'(gnt), 32'h1);

        // Random traffic with sticky requests so holds and timeouts both occur.
        r = 4'b0000;
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            cycle(r, "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
